// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI command sequencer: FSM encoding,
// command field widths and default timeouts.
package spi_pkg;

    localparam int RW_W    = 1;
    localparam int ADDR_W  = 7;
    localparam int WDATA_W = 8;
    localparam int CMD_W   = RW_W + ADDR_W + WDATA_W;

    localparam int DEF_FIFO_DEPTH   = 8;
    localparam int DEF_ACK_TIMEOUT  = 16;
    localparam int DEF_DONE_TIMEOUT = 64;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_CAPTURE   = 3'd4,
        ST_RESP      = 3'd5
    } state_t;

    typedef struct packed {
        logic               rw;
        logic [ADDR_W-1:0]  addr;
        logic [WDATA_W-1:0] wdata;
    } cmd_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; the head entry is visible on dout whenever
// the FIFO is not empty. Pushes while full are dropped even if a pop occurs.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Queues host register commands and plays them one at a time into an SPI
// engine, with start/done timeouts and a read-response handshake.
module spi_cmd_sequencer
    import spi_pkg::*;
#(
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int ACK_TIMEOUT  = DEF_ACK_TIMEOUT,
    parameter int DONE_TIMEOUT = DEF_DONE_TIMEOUT
) (
    input  logic        FSM_Clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [6:0]  cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [6:0]  rsp_addr,
    output logic [7:0]  rsp_data,
    output logic        spi_start,
    output logic [31:0] spi_mode,
    output logic [31:0] spi_slave_reg,
    output logic [31:0] spi_data_in,
    input  logic        spi_ready,
    input  logic [31:0] spi_data_out,
    output logic        busy,
    output logic        err_timeout,
    output logic [7:0]  cmd_count
);

    localparam int TMO_MAX = max_int(ACK_TIMEOUT, DONE_TIMEOUT);
    localparam int TMO_W   = $clog2(TMO_MAX + 1);
    localparam logic [TMO_W-1:0] ACK_LAST  = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] DONE_LAST = TMO_W'(DONE_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE   = 1;

    state_t           state;
    state_t           state_nx;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_cnt_nx;
    logic [CMD_W-1:0] fifo_dout;
    cmd_t             head;
    cmd_t             cur;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             tmo_hit;
    logic             done_cmd;
    logic             cap_rd;
    logic             unused_data_hi;

    assign unused_data_hi = ^spi_data_out[31:8];

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (FSM_Clk),
        .rst   (rst),
        .push  (cmd_valid),
        .din   ({cmd_rw, cmd_addr, cmd_wdata}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head      = cmd_t'(fifo_dout);
    assign cmd_ready = !fifo_full;
    // Start is decoded from state so it can only be high while in ISSUE.
    assign spi_start = (state == ST_ISSUE);
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    assign spi_mode      = {31'b0, cur.rw};
    assign spi_slave_reg = {25'b0, cur.addr};
    assign spi_data_in   = {24'b0, cur.wdata};

    always_ff @(posedge FSM_Clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nx;
            tmo_cnt <= tmo_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        tmo_cnt_nx = '0;
        pop        = 1'b0;
        tmo_hit    = 1'b0;
        done_cmd   = 1'b0;
        cap_rd     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && spi_ready) begin
                    pop      = 1'b1;
                    state_nx = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_nx = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!spi_ready) begin
                    state_nx = ST_WAIT_DONE;
                end else if (tmo_cnt == ACK_LAST) begin
                    tmo_hit  = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    tmo_cnt_nx = tmo_cnt + TMO_ONE;
                end
            end
            ST_WAIT_DONE: begin
                if (spi_ready) begin
                    state_nx = ST_CAPTURE;
                end else if (tmo_cnt == DONE_LAST) begin
                    tmo_hit  = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    tmo_cnt_nx = tmo_cnt + TMO_ONE;
                end
            end
            ST_CAPTURE: begin
                if (cur.rw) begin
                    done_cmd = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    cap_rd   = 1'b1;
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    done_cmd = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Command latched at the pop edge so the engine fields are valid in LOAD.
    always_ff @(posedge FSM_Clk or posedge rst) begin
        if (rst) begin
            cur <= '0;
        end else if (pop) begin
            cur <= head;
        end
    end

    always_ff @(posedge FSM_Clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_addr  <= '0;
        end else if (cap_rd) begin
            rsp_valid <= 1'b1;
            rsp_data  <= spi_data_out[7:0];
            rsp_addr  <= cur.addr;
        end else if ((state == ST_RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge FSM_Clk or posedge rst) begin
        if (rst) begin
            cmd_count   <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (done_cmd) begin
                cmd_count <= cmd_count + 8'd1;
            end
            if (tmo_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer with a reactive SPI engine model.
module tb_spi_cmd_sequencer;

    logic        FSM_Clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rw = 1'b0;
    logic [6:0]  cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [6:0]  rsp_addr;
    logic [7:0]  rsp_data;
    logic        spi_start;
    logic [31:0] spi_mode;
    logic [31:0] spi_slave_reg;
    logic [31:0] spi_data_in;
    logic        spi_ready = 1'b1;
    logic [31:0] spi_data_out = '0;
    logic        busy;
    logic        err_timeout;
    logic [7:0]  cmd_count;

    int total = 0;
    int bad = 0;

    // Engine model controls and observations
    logic        stall = 1'b0;
    logic        no_ack = 1'b0;
    int          eng_lat = 3;
    logic [7:0]  rd_val = 8'h00;
    int          eng_left = 0;
    int          eng_starts = 0;
    int          start_cycles = 0;
    logic        rsp_seen = 1'b0;
    logic [15:0] eng_log[$];

    spi_cmd_sequencer dut (
        .FSM_Clk       (FSM_Clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_rw        (cmd_rw),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_addr      (rsp_addr),
        .rsp_data      (rsp_data),
        .spi_start     (spi_start),
        .spi_mode      (spi_mode),
        .spi_slave_reg (spi_slave_reg),
        .spi_data_in   (spi_data_in),
        .spi_ready     (spi_ready),
        .spi_data_out  (spi_data_out),
        .busy          (busy),
        .err_timeout   (err_timeout),
        .cmd_count     (cmd_count)
    );

    always #5 FSM_Clk = ~FSM_Clk;

    // Engine: acknowledges a start by dropping ready, stays busy eng_lat cycles.
    always @(negedge FSM_Clk) begin
        spi_data_out = {24'h0, rd_val};
        if (spi_start) start_cycles++;
        if (rsp_valid) rsp_seen = 1'b1;
        if (rst) begin
            spi_ready = 1'b1;
            eng_left  = 0;
        end else if (stall) begin
            spi_ready = 1'b0;
        end else if (eng_left > 0) begin
            eng_left--;
            if (eng_left == 0) spi_ready = 1'b1;
        end else begin
            spi_ready = 1'b1;
            if (spi_start && !no_ack) begin
                spi_ready = 1'b0;
                eng_left  = eng_lat;
                eng_starts++;
                eng_log.push_back({spi_mode[0], spi_slave_reg[6:0], spi_data_in[7:0]});
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic rw, input logic [6:0] a, input logic [7:0] d);
        int n = 0;
        @(negedge FSM_Clk);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 300) begin
            @(negedge FSM_Clk);
            n++;
        end
        if (n >= 300) chk("push_wait", {31'b0, cmd_ready}, 32'd1);
        @(posedge FSM_Clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        @(negedge FSM_Clk);
        while (busy && n < budget) begin
            @(negedge FSM_Clk);
            n++;
        end
        chk(tag, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_cnt;
        int base_starts;

        // Reset state
        repeat (3) @(negedge FSM_Clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_start", {31'b0, spi_start}, 32'd0);
        chk("rst_mode", spi_mode, 32'd0);
        chk("rst_count", {24'b0, cmd_count}, 32'd0);
        #2 rst = 1'b0;

        // Single write, latency and field mapping
        eng_lat = 3;
        eng_log.delete();
        start_cycles = 0;
        push(1'b1, 7'h12, 8'hA5);
        chk("wr_start_c1", {31'b0, spi_start}, 32'd0);
        @(posedge FSM_Clk); #1;
        chk("wr_start_c2", {31'b0, spi_start}, 32'd0);
        chk("wr_mode", spi_mode, 32'h1);
        chk("wr_slave", spi_slave_reg, 32'h12);
        chk("wr_din", spi_data_in, 32'hA5);
        @(posedge FSM_Clk); #1;
        chk("wr_start_c3", {31'b0, spi_start}, 32'd1);
        wait_idle("wr_idle", 100);
        chk("wr_start_len", start_cycles, 32'd1);
        chk("wr_count", {24'b0, cmd_count}, 32'd1);
        chk("wr_no_rsp", {31'b0, rsp_seen}, 32'd0);
        chk("wr_log", (eng_log.size() > 0) ? {16'b0, eng_log[0]} : 32'hFFFF_FFFF, 32'h92A5);

        // Read with stalled response, followed by a queued write
        eng_log.delete();
        rd_val = 8'h3C;
        push(1'b0, 7'h05, 8'h00);
        push(1'b1, 7'h06, 8'h77);
        begin
            int n = 0;
            while (!rsp_valid && n < 100) begin
                @(negedge FSM_Clk);
                n++;
            end
        end
        chk("rd_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rd_addr", {25'b0, rsp_addr}, 32'h05);
        chk("rd_data", {24'b0, rsp_data}, 32'h3C);
        base_starts = eng_starts;
        rd_val = 8'hFF;
        repeat (10) @(negedge FSM_Clk);
        chk("rd_hold_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rd_hold_addr", {25'b0, rsp_addr}, 32'h05);
        chk("rd_hold_data", {24'b0, rsp_data}, 32'h3C);
        chk("rd_blocked", eng_starts, base_starts);
        chk("rd_hold_count", {24'b0, cmd_count}, 32'd1);
        rsp_ready = 1'b1;
        @(posedge FSM_Clk); #1;
        rsp_ready = 1'b0;
        chk("rd_hs_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rd_hs_count", {24'b0, cmd_count}, 32'd2);
        wait_idle("rd_idle", 100);
        chk("rd_after_count", {24'b0, cmd_count}, 32'd3);
        chk("rd_log_n", eng_log.size(), 32'd2);
        chk("rd_log0", (eng_log.size() > 0) ? {16'b0, eng_log[0]} : 32'hFFFF_FFFF, 32'h0500);
        chk("rd_log1", (eng_log.size() > 1) ? {16'b0, eng_log[1]} : 32'hFFFF_FFFF, 32'h8677);

        // FIFO full with FSM stalled, ninth push waits for the first pop
        eng_log.delete();
        base_cnt = cmd_count;
        stall = 1'b1;
        repeat (2) @(negedge FSM_Clk);
        for (int i = 0; i < 8; i++) begin
            push(1'b1, 7'(32 + i), 8'(i));
            if (i == 6) chk("full_ready7", {31'b0, cmd_ready}, 32'd1);
        end
        chk("full_ready8", {31'b0, cmd_ready}, 32'd0);
        @(negedge FSM_Clk);
        cmd_valid = 1'b1;
        cmd_rw    = 1'b1;
        cmd_addr  = 7'h28;
        cmd_wdata = 8'h08;
        repeat (3) @(negedge FSM_Clk);
        chk("full_refuse", {31'b0, cmd_ready}, 32'd0);
        chk("full_no_start", eng_log.size(), 32'd0);
        stall = 1'b0;
        begin
            int n = 0;
            while (!cmd_ready && n < 50) begin
                @(negedge FSM_Clk);
                n++;
            end
        end
        chk("full_reopen", {31'b0, cmd_ready}, 32'd1);
        @(posedge FSM_Clk); #1;
        cmd_valid = 1'b0;
        wait_idle("full_idle", 500);
        chk("full_log_n", eng_log.size(), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < eng_log.size())
                chk($sformatf("full_order%0d", i), {16'b0, eng_log[i]}, {16'b0, 1'b1, 7'(32 + i), 8'(i)});
        end
        chk("full_count", {24'b0, cmd_count}, 32'((base_cnt + 9) % 256));

        // Acknowledge timeout, then a normal command
        base_cnt = cmd_count;
        no_ack = 1'b1;
        start_cycles = 0;
        push(1'b1, 7'h33, 8'h44);
        wait_idle("ack_idle", 100);
        chk("ack_start_len", start_cycles, 32'd16);
        chk("ack_start_low", {31'b0, spi_start}, 32'd0);
        chk("ack_err", {31'b0, err_timeout}, 32'd1);
        chk("ack_count", {24'b0, cmd_count}, 32'(base_cnt));
        no_ack = 1'b0;
        push(1'b1, 7'h34, 8'h55);
        wait_idle("ack_next_idle", 100);
        chk("ack_next_count", {24'b0, cmd_count}, 32'((base_cnt + 1) % 256));
        chk("ack_err_sticky", {31'b0, err_timeout}, 32'd1);

        // Reset during WAIT_DONE with three commands queued
        eng_lat = 20;
        for (int i = 0; i < 4; i++) push(1'b1, 7'(64 + i), 8'(i));
        begin
            int n = 0;
            while (spi_ready && n < 50) begin
                @(negedge FSM_Clk);
                n++;
            end
        end
        chk("mid_engine_busy", {31'b0, spi_ready}, 32'd0);
        @(negedge FSM_Clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_start", {31'b0, spi_start}, 32'd0);
        chk("mid_ready", {31'b0, cmd_ready}, 32'd1);
        chk("mid_busy", {31'b0, busy}, 32'd0);
        chk("mid_err", {31'b0, err_timeout}, 32'd0);
        chk("mid_count", {24'b0, cmd_count}, 32'd0);
        chk("mid_rsp", {16'b0, rsp_valid, rsp_addr, rsp_data}, 32'd0);
        chk("mid_spi", spi_mode | spi_slave_reg | spi_data_in, 32'd0);
        @(negedge FSM_Clk);
        #2;
        start_cycles = 0;
        rst = 1'b0;
        repeat (30) @(negedge FSM_Clk);
        chk("mid_no_restart", start_cycles, 32'd0);
        chk("mid_idle", {31'b0, busy}, 32'd0);

        // 256 writes wrap the completion counter
        eng_lat = 1;
        for (int i = 0; i < 255; i++) push(1'b1, 7'(i), 8'(i));
        wait_idle("wrap_idle1", 3000);
        chk("wrap_255", {24'b0, cmd_count}, 32'd255);
        push(1'b1, 7'h7F, 8'hEE);
        wait_idle("wrap_idle2", 100);
        chk("wrap_0", {24'b0, cmd_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_cmd_sequencer.md
SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, command FIFO entries (power of 2, 2..64).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16, max cycles waiting for the engine to leave idle.
REQ-003 SHALL have parameter DONE_TIMEOUT, default 64, max cycles waiting for the engine to return to idle.
REQ-004 FSM_Clk  in  1  sole clock; all logic on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cmd_valid  in  1; cmd_ready  out  1  host command push handshake.
REQ-007 cmd_rw  in  1  (1=write, 0=read); cmd_addr  in  7  slave register; cmd_wdata  in  8  write byte.
REQ-008 rsp_valid  out  1; rsp_ready  in  1  read-response handshake.
REQ-009 rsp_addr  out  7; rsp_data  out  8  read-response payload.
REQ-010 spi_start  out  1; spi_mode  out  32; spi_slave_reg  out  32; spi_data_in  out  32  SPI engine request.
REQ-011 spi_ready  in  1 (engine idle); spi_data_out  in  32 (engine read byte in [7:0]).
REQ-012 busy  out  1; err_timeout  out  1 (sticky); cmd_count  out  8 (completed commands).

Function
REQ-013 Commands SHALL enter a FIFO_DEPTH FIFO; push when cmd_valid && cmd_ready; cmd_ready = !full; at full the push is refused even if a pop occurs that cycle.
REQ-014 FSM states SHALL be IDLE, LOAD, ISSUE, WAIT_DONE, CAPTURE, RESP.
REQ-015 IDLE: FIFO non-empty && spi_ready -> pop the head and go to LOAD; otherwise stay.
REQ-016 LOAD: drive spi_slave_reg = {25'b0, addr}, spi_mode = {31'b0, rw}, spi_data_in = {24'b0, wdata}, and hold them stable until the next LOAD; -> ISSUE.
REQ-017 ISSUE: spi_start=1; spi_ready sampled low -> deassert spi_start the same edge and go to WAIT_DONE.
REQ-018 ISSUE: ACK_TIMEOUT cycles without spi_ready low -> spi_start=0, err_timeout=1, discard the command, go to IDLE.
REQ-019 spi_start SHALL be 1 only in ISSUE, so the engine is never re-triggered on returning to idle.
REQ-020 WAIT_DONE: spi_ready sampled high -> CAPTURE; DONE_TIMEOUT cycles without it -> err_timeout=1, go to IDLE.
REQ-021 CAPTURE: read -> latch spi_data_out[7:0] into rsp_data and addr into rsp_addr, set rsp_valid, go to RESP; write -> increment cmd_count, go to IDLE.
REQ-022 RESP: hold rsp_* stable while rsp_valid && !rsp_ready; on handshake clear rsp_valid, increment cmd_count, go to IDLE.
REQ-023 cmd_count SHALL increment by 1 and wrap 255->0; timed-out commands do not count.
REQ-024 busy = (state != IDLE) || FIFO non-empty.
REQ-025 err_timeout SHALL clear only on rst; commands after a timeout proceed normally.
REQ-026 Minimum issue latency, push to spi_start high, SHALL be 3 cycles (FIFO write, IDLE pop, LOAD).

Reset
REQ-027 On rst, asynchronously: state=IDLE, FIFO empty, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_addr=0, spi_start=0, spi_mode=0, spi_slave_reg=0, spi_data_in=0, busy=0, err_timeout=0, cmd_count=0, timeout counters=0.
REQ-028 rst mid-transfer SHALL drop spi_start immediately and discard all queued commands and any pending response.

Structure
REQ-029 The state encoding, the command field widths (7/8/1) and the default timeouts SHALL live in the shared package spi_pkg.
REQ-030 The command FIFO SHALL be the sub-module sync_fifo, with parameterised width and depth and async active-high reset.

Verification
REQ-031 Write 0x12<-0xA5 with the engine model idle -> spi_mode=1, spi_slave_reg=0x12, spi_data_in=0xA5, spi_start high for exactly one cycle before spi_ready falls, cmd_count=1, no rsp_valid.
REQ-032 Read 0x05 with the model returning 0x3C -> rsp_valid, rsp_addr=0x05, rsp_data=0x3C; holding rsp_ready=0 for 10 cycles keeps rsp_* stable and blocks the next queued command.
REQ-033 Push 9 commands back-to-back with the FSM stalled, FIFO_DEPTH=8 -> cmd_ready falls after the 8th push, the 9th is accepted only after the first pop; all execute in order.
REQ-034 Engine model never drops spi_ready -> after 16 cycles spi_start=0, err_timeout=1, cmd_count unchanged, and the next command completes.
REQ-035 Assert rst during WAIT_DONE with 3 commands queued -> all outputs take reset values the same cycle; after rst no spi_start occurs until a new push.
REQ-036 Complete 256 writes -> cmd_count wraps to 0.
